// File: rtl/btn_conditioner.sv
// Four-button conditioner: synchronizer, debounce, press one-shot,
// optional hold-to-repeat and an any-key press tick.
module btn_conditioner #(
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       enable,
  output logic       btn_up_tick,
  output logic       btn_down_tick,
  output logic       btn_left_tick,
  output logic       btn_right_tick,
  output logic       any_tick,
  output logic [3:0] btn_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [3:0] IDLE =
    (BTN_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] r_stable;
  logic [3:0] r_held;
  logic [3:0] r_tick;
  logic       r_any;
  logic [3:0] w_p;
  logic [3:0] w_rise;
  logic [3:0] w_rep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= IDLE;
      r_s2 <= IDLE;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  assign w_p = (BTN_ACTIVE_LOW != 0) ? ~r_s2 : r_s2;
  assign w_rise = r_stable & ~r_held;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt       <= '0;
        r_stable[i] <= 1'b0;
      end else if (w_p[i] == r_stable[i]) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt       <= '0;
        r_stable[i] <= w_p[i];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    if (REPEAT_EN != 0) begin : g_rep
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW = $clog2(RMAX) + 1;
      logic [RW-1:0] r_rcnt;
      logic          r_first;
      logic [RW-1:0] w_lim;
      logic          w_clr;

      assign w_lim = r_first ? RW'(REPEAT_DELAY - 1)
                             : RW'(REPEAT_PERIOD - 1);
      assign w_clr = !r_stable[i] || !enable || w_rise[i];
      assign w_rep[i] = !w_clr && (r_rcnt == w_lim);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rcnt  <= '0;
          r_first <= 1'b1;
        end else if (w_clr) begin
          r_rcnt  <= '0;
          r_first <= 1'b1;
        end else if (r_rcnt == w_lim) begin
          r_rcnt  <= '0;
          r_first <= 1'b0;
        end else begin
          r_rcnt <= r_rcnt + 1'b1;
        end
      end
    end else begin : g_norep
      assign w_rep[i] = 1'b0;
    end
  end

  // r_held lags r_stable by one cycle so the rising edge is seen once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= 4'h0;
      r_tick <= 4'h0;
      r_any  <= 1'b0;
    end else begin
      r_held <= r_stable;
      r_tick <= (w_rise | w_rep) & {4{enable}};
      r_any  <= (|w_rise) & enable;
    end
  end

  assign btn_up_tick    = r_tick[0];
  assign btn_down_tick  = r_tick[1];
  assign btn_left_tick  = r_tick[2];
  assign btn_right_tick = r_tick[3];
  assign any_tick       = r_any;
  assign btn_held       = r_held;

endmodule
